// File: rtl/iter_div_pkg.sv
// Shared widths, step count and FSM state type for the iterative divider.
package iter_div_pkg;

    localparam int DIV_W     = 32;
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v, input logic is_signed);
        return (is_signed && v[DIV_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/iter_div_operand_buf.sv
// One-entry valid/ready holding register for a divider operand channel.
module div_operand_buf
    import iter_div_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             tvalid,
    output logic             tready,
    input  logic [DIV_W-1:0] tdata,
    output logic [DIV_W-1:0] data,
    output logic             full
);

    assign tready = ~full;

    // clr wins over a same-edge handshake so a flushed cycle captures nothing
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full <= 1'b0;
            data <= '0;
        end else if (clr) begin
            full <= 1'b0;
        end else if (tvalid && !full) begin
            full <= 1'b1;
            data <= tdata;
        end
    end

endmodule

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider, 34-edge fixed latency.
// Optional ITER_DIV_FLUSH_EN adds a flush input that aborts the operation.
module iter_div
    import iter_div_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
`ifdef ITER_DIV_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [DIV_W-1:0]     s_axis_divisor_tdata,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [DIV_W-1:0]     s_axis_dividend_tdata,
    output logic                 m_axis_dout_tvalid,
    output logic [2*DIV_W-1:0]   m_axis_dout_tdata
);

    logic flush_q;
`ifdef ITER_DIV_FLUSH_EN
    assign flush_q = flush;
`else
    assign flush_q = 1'b0;
`endif

    div_state_t        state, state_next;
    logic [CNT_W-1:0]  count;
    logic [DIV_W-1:0]  part_rem, quo_acc, dsr;
    logic              q_neg, r_neg, div_zero;
    logic              dvs_full, dvd_full, start, buf_clr;
    logic [DIV_W-1:0]  dvs_buf, dvd_buf;
    logic [DIV_W:0]    shifted, trial;
    logic [DIV_W-1:0]  q_out, r_out;

    assign start   = (state == IDLE) && dvs_full && dvd_full && !flush_q;
    assign buf_clr = start || flush_q;

    div_operand_buf u_divisor_buf (
        .clk    (clk),
        .resetn (resetn),
        .clr    (buf_clr),
        .tvalid (s_axis_divisor_tvalid),
        .tready (s_axis_divisor_tready),
        .tdata  (s_axis_divisor_tdata),
        .data   (dvs_buf),
        .full   (dvs_full)
    );

    div_operand_buf u_dividend_buf (
        .clk    (clk),
        .resetn (resetn),
        .clr    (buf_clr),
        .tvalid (s_axis_dividend_tvalid),
        .tready (s_axis_dividend_tready),
        .tdata  (s_axis_dividend_tdata),
        .data   (dvd_buf),
        .full   (dvd_full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (dvs_full && dvd_full) state_next = CALC;
            CALC:    if (count == CNT_W'(DIV_STEPS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_q) state_next = IDLE;
    end

    // Trial subtract never overflows 33 bits because part_rem < dsr between steps
    assign shifted = {part_rem, quo_acc[DIV_W-1]};
    assign trial   = shifted - {1'b0, dsr};

    // A zero divisor leaves quotient all-ones and |dividend| in part_rem; the
    // remainder sign fix then restores the original dividend
    assign q_out = (q_neg && !div_zero) ? -quo_acc : quo_acc;
    assign r_out = r_neg ? -part_rem : part_rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count              <= '0;
            part_rem           <= '0;
            quo_acc            <= '0;
            dsr                <= '0;
            q_neg              <= 1'b0;
            r_neg              <= 1'b0;
            div_zero           <= 1'b0;
            m_axis_dout_tvalid <= 1'b0;
            m_axis_dout_tdata  <= '0;
        end else begin
            m_axis_dout_tvalid <= 1'b0;
            if (flush_q) begin
                count <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        quo_acc  <= abs_val(dvd_buf, SIGNED);
                        dsr      <= abs_val(dvs_buf, SIGNED);
                        part_rem <= '0;
                        q_neg    <= SIGNED && (dvd_buf[DIV_W-1] ^ dvs_buf[DIV_W-1]);
                        r_neg    <= SIGNED && dvd_buf[DIV_W-1];
                        div_zero <= (dvs_buf == '0);
                        count    <= '0;
                    end
                    CALC: begin
                        if (!trial[DIV_W]) begin
                            part_rem <= trial[DIV_W-1:0];
                            quo_acc  <= {quo_acc[DIV_W-2:0], 1'b1};
                        end else begin
                            part_rem <= shifted[DIV_W-1:0];
                            quo_acc  <= {quo_acc[DIV_W-2:0], 1'b0};
                        end
                        count <= count + 1'b1;
                    end
                    DONE: begin
                        m_axis_dout_tvalid <= 1'b1;
                        m_axis_dout_tdata  <= {q_out, r_out};
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// Directed bench for iter_div: unsigned and signed instances share stimulus,
// checked every cycle against a transaction-level model plus literal results.
module tb_iter_div;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush_drv = 1'b0;
    logic        dvs_v = 1'b0, dvd_v = 1'b0;
    logic [31:0] dvs_d = '0, dvd_d = '0;

    logic        dvs_rdy_u, dvd_rdy_u, vld_u;
    logic        dvs_rdy_s, dvd_rdy_s, vld_s;
    logic [63:0] dat_u, dat_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iter_div #(.SIGNED(1'b0)) dut_u (
        .clk                    (clk),
        .resetn                 (resetn),
`ifdef ITER_DIV_FLUSH_EN
        .flush                  (flush_drv),
`endif
        .s_axis_divisor_tvalid  (dvs_v),
        .s_axis_divisor_tready  (dvs_rdy_u),
        .s_axis_divisor_tdata   (dvs_d),
        .s_axis_dividend_tvalid (dvd_v),
        .s_axis_dividend_tready (dvd_rdy_u),
        .s_axis_dividend_tdata  (dvd_d),
        .m_axis_dout_tvalid     (vld_u),
        .m_axis_dout_tdata      (dat_u)
    );

    iter_div #(.SIGNED(1'b1)) dut_s (
        .clk                    (clk),
        .resetn                 (resetn),
`ifdef ITER_DIV_FLUSH_EN
        .flush                  (flush_drv),
`endif
        .s_axis_divisor_tvalid  (dvs_v),
        .s_axis_divisor_tready  (dvs_rdy_s),
        .s_axis_divisor_tdata   (dvs_d),
        .s_axis_dividend_tvalid (dvd_v),
        .s_axis_dividend_tready (dvd_rdy_s),
        .s_axis_dividend_tdata  (dvd_d),
        .m_axis_dout_tvalid     (vld_s),
        .m_axis_dout_tdata      (dat_s)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result of one divide, from the arithmetic rules alone
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        sa = a;
        sb = b;
        return {32'(sa / sb), 32'(sa % sb)};
    endfunction

    // Transaction model: buffers, a busy window of 34 edges, then a pulse
    bit          m_dvs_full = 0, m_dvd_full = 0, busy = 0, was_busy;
    int          left = 0;
    logic [31:0] m_dvs = '0, m_dvd = '0;
    logic [63:0] res_u = '0, res_s = '0, exp_u = '0, exp_s = '0;
    bit          exp_vld = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_dvs_full = 0; m_dvd_full = 0; busy = 0; left = 0;
            exp_vld = 0; exp_u = '0; exp_s = '0;
        end else begin
            exp_vld = 0;
            if (flush_drv) begin
                m_dvs_full = 0; m_dvd_full = 0; busy = 0; left = 0;
            end else begin
                was_busy = busy;
                if (busy) begin
                    left--;
                    if (left == 0) begin
                        exp_vld = 1; exp_u = res_u; exp_s = res_s; busy = 0;
                    end
                end
                if (!was_busy && m_dvs_full && m_dvd_full) begin
                    res_u = ref_div(1'b0, m_dvd, m_dvs);
                    res_s = ref_div(1'b1, m_dvd, m_dvs);
                    busy = 1; left = 33;
                    m_dvs_full = 0; m_dvd_full = 0;
                end else begin
                    if (dvs_v && !m_dvs_full) begin m_dvs_full = 1; m_dvs = dvs_d; end
                    if (dvd_v && !m_dvd_full) begin m_dvd_full = 1; m_dvd = dvd_d; end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("vld_u", {63'd0, vld_u}, {63'd0, exp_vld});
        check("vld_s", {63'd0, vld_s}, {63'd0, exp_vld});
        check("dat_u", dat_u, exp_u);
        check("dat_s", dat_s, exp_s);
        check("dvs_rdy", {62'd0, dvs_rdy_u, dvs_rdy_s}, {62'd0, !m_dvs_full, !m_dvs_full});
        check("dvd_rdy", {62'd0, dvd_rdy_u, dvd_rdy_s}, {62'd0, !m_dvd_full, !m_dvd_full});
    end

    task automatic send_pair(input logic [31:0] dvd, input logic [31:0] dvs);
        bit hd, hs;
        dvd_d = dvd; dvs_d = dvs; dvd_v = 1'b1; dvs_v = 1'b1;
        for (int i = 0; i < 200 && (dvd_v || dvs_v); i++) begin
            hd = dvd_v && dvd_rdy_u;
            hs = dvs_v && dvs_rdy_u;
            @(posedge clk); #1;
            if (hd) dvd_v = 1'b0;
            if (hs) dvs_v = 1'b0;
        end
        if (dvd_v || dvs_v) begin
            total++; bad++;
            $display("FAIL send_timeout: got valid still high expected handshake");
            dvd_v = 1'b0; dvs_v = 1'b0;
        end
    endtask

    task automatic wait_result(input string name, input logic [63:0] eu, input logic [63:0] es, input int lat);
        int n = 0;
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            n = i;
            if (vld_u) break;
        end
        check({name, "_latency"}, 64'(n), 64'(lat));
        check({name, "_u"}, dat_u, eu);
        check({name, "_s"}, dat_s, es);
        @(posedge clk); #1;
        check({name, "_pulse_end"}, {63'd0, vld_u}, 64'd0);
    endtask

    task automatic expect_no_pulse(input string name, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (vld_u || vld_s) pulses++;
        end
        check(name, 64'(pulses), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", {62'd0, dvs_rdy_u, dvd_rdy_u}, 64'd3);
        check("rst_out", {vld_u, dat_u[62:0]}, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        send_pair(32'd100, 32'd7);
        wait_result("div_100_7", 64'h0000000E_00000002, 64'h0000000E_00000002, 34);

        send_pair(32'hFFFF_FFF9, 32'd2);
        wait_result("div_m7_2", 64'h7FFFFFFC_00000001, 64'hFFFFFFFD_FFFFFFFF, 34);

        send_pair(32'h1234_5678, 32'd0);
        wait_result("div_zero", 64'hFFFFFFFF_12345678, 64'hFFFFFFFF_12345678, 34);

        send_pair(32'hFFFF_FFF9, 32'd0);
        wait_result("div_zero_neg", 64'hFFFFFFFF_FFFFFFF9, 64'hFFFFFFFF_FFFFFFF9, 34);

        send_pair(32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("overflow", 64'h00000000_80000000, 64'h80000000_00000000, 34);

        // Skewed channels with divisor held valid and changing while full
        dvs_v = 1'b1; dvs_d = 32'd5;
        @(posedge clk); #1;
        check("skew_dvs_rdy_low", {63'd0, dvs_rdy_u}, 64'd0);
        dvs_d = 32'd99;
        repeat (4) @(posedge clk);
        #1;
        dvd_v = 1'b1; dvd_d = 32'd47;
        @(posedge clk); #1;
        dvs_v = 1'b0; dvd_v = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        send_pair(32'd1000, 32'd33);
        wait_result("skew", 64'h00000009_00000002, 64'h00000009_00000002, 28);
        wait_result("queued", 64'h0000001E_0000000A, 64'h0000001E_0000000A, 33);

        // Asynchronous reset at count 10
        send_pair(32'd55, 32'd4);
        repeat (11) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midrst_rdy", {62'd0, dvs_rdy_u, dvd_rdy_u}, 64'd3);
        check("midrst_dat", dat_u, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        expect_no_pulse("midrst_no_pulse", 40);
        send_pair(32'd9, 32'd3);
        wait_result("after_rst", 64'h00000003_00000000, 64'h00000003_00000000, 34);

`ifdef ITER_DIV_FLUSH_EN
        send_pair(32'd200, 32'd9);
        repeat (10) @(posedge clk);
        #1 flush_drv = 1'b1;
        @(posedge clk); #1;
        flush_drv = 1'b0;
        check("flush_hold", dat_u, 64'h00000003_00000000);
        expect_no_pulse("flush_no_pulse", 40);
        send_pair(32'd200, 32'd9);
        wait_result("after_flush", 64'h00000016_00000002, 64'h00000016_00000002, 34);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iter_div.md
# iter_div

Iterative 32-bit radix-2 restoring divider that responds to the execute stage's divide request. It accepts divisor and dividend on two independent valid/ready operand channels, computes for a fixed number of cycles, and returns `{quotient, remainder}` on a single-cycle valid result channel. It is instantiated once with `SIGNED=1` for div.w/mod.w and once with `SIGNED=0` for div.wu/mod.wu.

## Interface
- `SIGNED`, default 1: 1 selects two's-complement operands and results; 0 selects unsigned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `s_axis_divisor_tvalid`  in  1  divisor offered.
- `s_axis_divisor_tready`  out  1  divisor holding buffer empty.
- `s_axis_divisor_tdata`  in  32  divisor.
- `s_axis_dividend_tvalid`  in  1  dividend offered.
- `s_axis_dividend_tready`  out  1  dividend holding buffer empty.
- `s_axis_dividend_tdata`  in  32  dividend.
- `m_axis_dout_tvalid`  out  1  one-cycle result pulse. There is no output ready; the consumer must sample on the pulse.
- `m_axis_dout_tdata`  out  64  `[63:32]` quotient, `[31:0]` remainder.
- `flush`  in  1  present only with `ITER_DIV_FLUSH_EN` (see Configuration).

## Operation
- **Operand buffers**
  - Each channel has a one-entry buffer.
  - `tready` equals buffer empty, combinationally.
  - A handshake (`tvalid & tready` at an edge) stores `tdata` and sets the buffer full.
  - The two channels complete independently, in any order or in the same cycle.
  - No second capture is possible while a buffer is full.
- **FSM states: IDLE, CALC, DONE.**
  - **IDLE:** when both buffers are full, the next edge does four things:
    - loads the working registers with `|dividend|` and `|divisor|` (raw values when `SIGNED=0`);
    - latches the quotient sign (signs differ) and the remainder sign (dividend sign);
    - empties both buffers;
    - sets count=0 and moves to CALC.
  - **CALC:** one restoring step per cycle.
    - Shift the partial remainder left, taking the next quotient bit.
    - Compute a 33-bit trial subtract; if it is non-negative, keep it and set the quotient bit to 1.
    - count increments; the edge at count==31 moves to DONE.
  - **DONE:** one edge registers the sign-corrected result into `m_axis_dout_tdata`, pulses `m_axis_dout_tvalid` for the following cycle, and returns to IDLE.
- **Sign correction (`SIGNED=1` only):** negate the quotient if the quotient sign is set; negate the remainder if the dividend was negative.
- **Divisor = 0:** quotient 0xFFFFFFFF, remainder = original dividend, no sign correction, in both modes. Latency is unchanged.
- **Signed overflow 0x80000000 / 0xFFFFFFFF:** quotient 0x80000000, remainder 0. This falls out of 32-bit wrap arithmetic.
- **Buffering:** the buffers refill during CALC/DONE, so the next operation can be queued. If both buffers are full on return to IDLE, the next operation starts on the following edge.
- **Result hold:** `m_axis_dout_tdata` holds its value until the next DONE.

## Timing
- **Reset values:** state IDLE, both buffers empty (both `tready`=1 during and after reset), `m_axis_dout_tvalid`=0, `m_axis_dout_tdata`=0, count=0.
- **Reset mid-operation:** an asynchronous `resetn` assertion in any state aborts immediately. No result pulse is produced, and buffered operands are lost.
- **Latency:** let E0 be the edge where the second handshake completes.
  - IDLE→CALC at E1.
  - 32 CALC edges at E2..E33; DONE entered at E33.
  - `m_axis_dout_tvalid` high from E34 to E35.
  - Latency is 34 edges regardless of operand values.
- **Throughput:** one result per 34 cycles with operands pre-queued.
- **`tready` behaviour:**
  - `tready` drops in the cycle after a capture and rises in the cycle after E1.
  - A requester that holds `tvalid` until both `tready`s are high is served on the first cycle both buffers are empty.

## Configuration
- `ITER_DIV_FLUSH_EN` defined:
  - the `flush` input exists;
  - `flush`=1 at an edge empties both buffers, forces IDLE, clears count, and suppresses any pending DONE pulse;
  - `m_axis_dout_tdata` is unchanged;
  - a handshake in a flush cycle is discarded.
- `ITER_DIV_FLUSH_EN` undefined: no `flush` port; an operation always runs to completion once started.

## Structure
- **Shared package:**
  - `DIV_W`=32;
  - `DIV_STEPS`=32;
  - state enum `div_state_t` {IDLE, CALC, DONE};
  - count width `$clog2(DIV_STEPS)`.
- **Sub-module `div_operand_buf`:** one-entry valid/ready holding register, instantiated twice (divisor, dividend). It has `clr` for the start edge and for flush.

## Test plan
- **Unsigned 100/7:** `SIGNED=0`, dividend 100, divisor 7, same cycle → `tdata`=0x0000000E_00000002, `tvalid` exactly one cycle, 34 edges after the handshake.
- **Signed -7/2:** `SIGNED=1`, dividend 0xFFFFFFF9, divisor 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- **Divide by zero and overflow:**
  - dividend 0x12345678, divisor 0 → 0xFFFFFFFF_12345678;
  - signed 0x80000000 / 0xFFFFFFFF → 0x80000000_00000000.
- **Channel skew:** divisor handshake at cycle 0 and dividend at cycle 5 → divisor `tready` low from cycle 1, no double capture, result 34 edges after cycle 5. Also queue a second pair during CALC → second result 34 edges after the first DONE.
- **Reset mid-CALC:** `resetn` low at count=10 → `tvalid` never pulses, both `tready`=1, `tdata`=0. A fresh 9/3 afterwards → 0x00000003_00000000.
- **Flush (with `ITER_DIV_FLUSH_EN`):** `flush` in CALC → no pulse, IDLE next cycle, previous `tdata` retained.
